// File: rtl/button_pulse_gen.sv
// Two active-low bouncing push buttons in, one-cycle inc/dec strobes out.
// Each button: 2-flop synchronizer, counter debouncer, press/auto-repeat FSM with conflict lock.
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_n,
    input  logic btn_down_n,
    output logic inc,
    output logic dec,
    output logic up_held,
    output logic down_held
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT,
        S_HOLD,
        S_LOCK
    } state_t;

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]       w_raw_n;
    logic [1:0]       r_meta_p0;
    logic [1:0]       r_sync_p1;
    logic [1:0]       r_held;
    logic [DB_W-1:0]  r_db_cnt [2];
    state_t           r_state [2];
    state_t           w_state_nxt [2];
    logic [TMR_W-1:0] r_timer [2];
    logic [TMR_W-1:0] w_timer_nxt [2];
    logic [1:0]       w_pulse;
    logic             w_both_held;
    logic             r_inc;
    logic             r_dec;

    assign w_raw_n     = {btn_down_n, btn_up_n};
    assign w_both_held = &r_held;

    // Synchronizer and debouncer stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta_p0 <= 2'b11;
            r_sync_p1 <= 2'b11;
            r_held    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_meta_p0 <= w_raw_n;
            r_sync_p1 <= r_meta_p0;
            for (int i = 0; i < 2; i++) begin
                // Sync is active-low, held is active-high: unequal bits mean agreement.
                if (r_sync_p1[i] != r_held[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_held[i]   <= ~r_held[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press / repeat FSM stage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= S_IDLE;
                r_timer[i] <= '0;
            end
            r_inc <= 1'b0;
            r_dec <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_timer[i] <= w_timer_nxt[i];
            end
            r_inc <= w_pulse[0];
            r_dec <= w_pulse[1] & ~w_pulse[0];
        end
    end

    always_comb begin
        w_pulse = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_state_nxt[i] = r_state[i];
            w_timer_nxt[i] = r_timer[i];
            if (r_state[i] == S_LOCK) begin
                // A locked button only leaves through its own release.
                if (!r_held[i]) begin
                    w_state_nxt[i] = S_IDLE;
                    w_timer_nxt[i] = '0;
                end
            end else if (w_both_held) begin
                w_state_nxt[i] = S_LOCK;
                w_timer_nxt[i] = '0;
            end else begin
                case (r_state[i])
                    S_IDLE: begin
                        if (r_held[i]) begin
                            w_pulse[i]     = 1'b1;
                            w_timer_nxt[i] = '0;
                            w_state_nxt[i] = (REPEAT_DELAY == 0) ? S_HOLD : S_DELAY;
                        end
                    end
                    S_DELAY: begin
                        if (!r_held[i]) begin
                            w_state_nxt[i] = S_IDLE;
                            w_timer_nxt[i] = '0;
                        end else if (r_timer[i] == DELAY_LAST) begin
                            w_pulse[i]     = 1'b1;
                            w_state_nxt[i] = S_REPEAT;
                            w_timer_nxt[i] = '0;
                        end else begin
                            w_timer_nxt[i] = r_timer[i] + 1'b1;
                        end
                    end
                    S_REPEAT: begin
                        if (!r_held[i]) begin
                            w_state_nxt[i] = S_IDLE;
                            w_timer_nxt[i] = '0;
                        end else if (r_timer[i] == PERIOD_LAST) begin
                            w_pulse[i]     = 1'b1;
                            w_timer_nxt[i] = '0;
                        end else begin
                            w_timer_nxt[i] = r_timer[i] + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (!r_held[i]) begin
                            w_state_nxt[i] = S_IDLE;
                            w_timer_nxt[i] = '0;
                        end
                    end
                    default: begin
                        w_state_nxt[i] = S_IDLE;
                        w_timer_nxt[i] = '0;
                    end
                endcase
            end
        end
    end

    assign inc       = r_inc;
    assign dec       = r_dec;
    assign up_held   = r_held[0];
    assign down_held = r_held[1];

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: directed scenarios plus random stimulus against a
// window/episode reference model; a second instance runs with auto-repeat disabled.
module tb_button_pulse_gen;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_up_n = 1'b1;
    logic btn_down_n = 1'b1;
    logic inc, dec, up_held, down_held;
    logic inc0, dec0, up_held0, down_held0;

    button_pulse_gen #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut (
        .clk(clk), .rst(rst), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
        .inc(inc), .dec(dec), .up_held(up_held), .down_held(down_held)
    );

    button_pulse_gen #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) u_dut0 (
        .clk(clk), .rst(rst), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
        .inc(inc0), .dec(dec0), .up_held(up_held0), .down_held(down_held0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Reference model state: global edge count, raw history, debounced levels, press episodes.
    int       g = 0;
    int       last_rst = 0;
    bit [1:0] raw_hist [0:8191];
    bit       m_lvl [2];
    int       ep_start [2][2];
    bit       ep_lock [2][2];
    bit       m_pulse [2][2];
    int       dly [2] = '{RD, 0};

    int s_edge;
    int inc_q[$], dec_q[$], inc0_q[$], dec0_q[$], exp_q[$];
    int up_rise, down_fall;
    bit prev_uh, prev_dh;

    task automatic chk(string tag, logic obs, logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b at edge %0d", tag, obs, expv, g);
        end
    endtask

    task automatic chk_int(string tag, int obs, int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_list(string tag, input int obs[$], input int expv[$]);
        chk_int({tag, "_count"}, obs.size(), expv.size());
        for (int i = 0; i < expv.size(); i++) begin
            chk_int(tag, (i < obs.size()) ? obs[i] : -1, expv[i]);
        end
    endtask

    function automatic bit sample_at(int e, int b);
        if (e - 2 > last_rst) return raw_hist[e - 2][b];
        return 1'b0;
    endfunction

    task automatic model_edge(bit r, bit up_p, bit dn_p);
        bit flip [2];
        raw_hist[g] = {dn_p, up_p};
        for (int m = 0; m < 2; m++)
            for (int b = 0; b < 2; b++) m_pulse[m][b] = 1'b0;
        if (r) begin
            last_rst = g;
            for (int b = 0; b < 2; b++) m_lvl[b] = 1'b0;
            for (int m = 0; m < 2; m++)
                for (int b = 0; b < 2; b++) begin
                    ep_start[m][b] = -1;
                    ep_lock[m][b] = 1'b0;
                end
        end else begin
            // Pulses: offset 0 of a press, then REPEAT_DELAY + k*REPEAT_PERIOD, unless a conflict was seen.
            for (int m = 0; m < 2; m++)
                for (int b = 0; b < 2; b++) begin
                    if (!m_lvl[b]) begin
                        ep_start[m][b] = -1;
                        ep_lock[m][b] = 1'b0;
                    end else begin
                        int off;
                        if (ep_start[m][b] < 0) ep_start[m][b] = g;
                        if (m_lvl[1 - b]) ep_lock[m][b] = 1'b1;
                        off = g - ep_start[m][b];
                        if (!ep_lock[m][b] && (off == 0 ||
                            (dly[m] > 0 && off >= dly[m] && (off - dly[m]) % RP == 0)))
                            m_pulse[m][b] = 1'b1;
                    end
                end
            // Level flips when the last DB post-reset samples all disagree with it.
            for (int b = 0; b < 2; b++) begin
                flip[b] = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    int e;
                    e = g - j;
                    if (e <= last_rst) flip[b] = 1'b0;
                    else if (sample_at(e, b) == m_lvl[b]) flip[b] = 1'b0;
                end
            end
            for (int b = 0; b < 2; b++) if (flip[b]) m_lvl[b] = ~m_lvl[b];
        end
    endtask

    task automatic step(bit up_p, bit dn_p, bit r);
        btn_up_n = ~up_p;
        btn_down_n = ~dn_p;
        rst = r;
        @(posedge clk);
        g++;
        s_edge++;
        model_edge(r, up_p, dn_p);
        #1;
        chk("inc", inc, m_pulse[0][0]);
        chk("dec", dec, m_pulse[0][1] & ~m_pulse[0][0]);
        chk("up_held", up_held, m_lvl[0]);
        chk("down_held", down_held, m_lvl[1]);
        chk("inc_nrpt", inc0, m_pulse[1][0]);
        chk("dec_nrpt", dec0, m_pulse[1][1] & ~m_pulse[1][0]);
        chk("up_held_nrpt", up_held0, m_lvl[0]);
        chk("down_held_nrpt", down_held0, m_lvl[1]);
        chk("mutex", inc & dec, 1'b0);
        if (inc) inc_q.push_back(s_edge);
        if (dec) dec_q.push_back(s_edge);
        if (inc0) inc0_q.push_back(s_edge);
        if (dec0) dec0_q.push_back(s_edge);
        if (up_held && !prev_uh && up_rise < 0) up_rise = s_edge;
        if (!down_held && prev_dh) down_fall = s_edge;
        prev_uh = up_held;
        prev_dh = down_held;
    endtask

    task automatic begin_scn();
        s_edge = -1;
        step(1'b0, 1'b0, 1'b1);
        inc_q.delete(); dec_q.delete(); inc0_q.delete(); dec0_q.delete();
        up_rise = -1;
        down_fall = -1;
    endtask

    initial begin
        for (int m = 0; m < 2; m++)
            for (int b = 0; b < 2; b++) ep_start[m][b] = -1;

        // Reset state
        begin_scn();
        chk("rst_inc", inc, 1'b0);
        chk("rst_dec", dec, 1'b0);
        chk("rst_up_held", up_held, 1'b0);
        chk("rst_down_held", down_held, 1'b0);

        // Clean short press
        begin_scn();
        for (int i = 1; i <= 10; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
        chk_int("clean_up_rise", up_rise, 6);
        exp_q = '{7};
        chk_list("clean_inc", inc_q, exp_q);
        chk_int("clean_dec_count", dec_q.size(), 0);

        // Auto-repeat on down
        begin_scn();
        for (int i = 1; i <= 39; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0);
        exp_q = '{7, 17, 20, 23, 26, 29, 32, 35, 38, 41, 44};
        chk_list("rpt_dec", dec_q, exp_q);
        chk_int("rpt_down_fall", down_fall, 45);
        chk_int("rpt_inc_count", inc_q.size(), 0);
        exp_q = '{7};
        chk_list("rpt_dec_nrpt", dec0_q, exp_q);

        // Bounce rejection
        begin_scn();
        for (int i = 0; i < 30; i++) step(((i / 2) % 2) == 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        chk_int("bounce_up_rise", up_rise, -1);
        chk_int("bounce_inc_count", inc_q.size(), 0);

        // Simultaneous press, then release up, then release and re-press down
        begin_scn();
        for (int e = 1; e <= 2; e++) step(1'b1, 1'b0, 1'b0);
        for (int e = 3; e <= 30; e++) step(1'b1, 1'b1, 1'b0);
        for (int e = 31; e <= 50; e++) step(1'b0, 1'b1, 1'b0);
        chk_int("simul_no_dec_while_locked", dec_q.size(), 0);
        for (int e = 51; e <= 70; e++) step(1'b0, 1'b0, 1'b0);
        for (int e = 71; e <= 80; e++) step(1'b0, 1'b1, 1'b0);
        for (int e = 81; e <= 100; e++) step(1'b0, 1'b0, 1'b0);
        exp_q = '{7};
        chk_list("simul_inc", inc_q, exp_q);
        exp_q = '{77};
        chk_list("simul_dec", dec_q, exp_q);
        chk_list("simul_dec_nrpt", dec0_q, exp_q);

        // Reset mid-hold
        begin_scn();
        for (int e = 1; e <= 39; e++) begin
            step(1'b1, 1'b0, e == 20);
            if (e == 20 || e == 21) begin
                chk("rstmid_inc", inc, 1'b0);
                chk("rstmid_up_held", up_held, 1'b0);
            end
        end
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0);
        exp_q = '{7, 17, 27, 37, 40, 43};
        chk_list("rstmid_inc_list", inc_q, exp_q);
        exp_q = '{7, 27};
        chk_list("rstmid_inc_nrpt", inc0_q, exp_q);

        // Auto-repeat disabled instance: one pulse per long press
        begin_scn();
        for (int i = 1; i <= 50; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
        exp_q = '{7};
        chk_list("nrpt_inc", inc0_q, exp_q);

        // Random stimulus against the model
        begin_scn();
        begin
            int cyc = 0;
            while (cyc < 1500) begin
                int len;
                bit up_p, dn_p;
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 6);
                up_p = $urandom_range(0, 1);
                dn_p = ($urandom_range(0, 2) == 0);
                for (int l = 0; l < len; l++) begin
                    step(up_p, dn_p, $urandom_range(0, 199) == 0);
                    cyc++;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
